// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 5208;
  localparam int DATA_BITS_DEFAULT    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer; wraps to zero on its own tick so consecutive bits need no clear.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TC = TW'(HALF - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == (half ? HALF_TC : FULL_TC));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, framing-error detect.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic                 sync1_q, rxs_q;
  logic [DATA_BITS-1:0] shreg_q, data_q;
  logic [IDXW-1:0]      idx_q;
  logic                 valid_q, ferr_q, busy_q;
  logic                 tmr_clear, tmr_half, tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      rxs_q   <= sync1_q;
    end
  end

  // Only IDLE and BREAK leave without a tick; every other exit rides the timer wrap.
  assign tmr_clear = (state_q == IDLE) || (state_q == BREAK);
  assign tmr_half  = (state_q == START);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .half  (tmr_half),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: if (!rxs_q) begin
          state_q <= START;
          busy_q  <= 1'b1;
        end
        START: if (tick) begin
          if (!rxs_q) begin
            state_q <= DATA;
            idx_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DATA: if (tick) begin
          shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_q <= STOP;
        end
        STOP: if (tick) begin
          if (rxs_q) begin
            data_q  <= shreg_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= BREAK;
          end
        end
        BREAK: if (rxs_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx at CLKS_PER_BIT=16 plus a CLKS_PER_BIT=4 instance.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx16 = 1'b1, rx4 = 1'b1;
  logic [7:0] data16, data4;
  logic       valid16, valid4, ferr16, ferr4, busy16, busy4;

  int vectors = 0, miscompares = 0;
  int cyc = 0, valid_cyc = -1;
  int nvalid16 = 0, nferr16 = 0, nvalid4 = 0, nferr4 = 0;
  logic [7:0] q16[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx16),
    .rx_data(data16), .rx_valid(valid16), .frame_err(ferr16), .rx_busy(busy16)
  );

  uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
    .clk(clk), .rst(rst), .rx_serial(rx4),
    .rx_data(data4), .rx_valid(valid4), .frame_err(ferr4), .rx_busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every strobe; pulses are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid16) begin
        nvalid16++;
        valid_cyc = cyc;
        check("valid_ferr_excl16", {31'd0, ferr16}, 32'd0);
        if (q16.size() == 0) check("unexpected_valid16", 32'd1, 32'd0);
        else check("rx_data16", {24'd0, data16}, {24'd0, q16.pop_front()});
      end
      if (ferr16) nferr16++;
      if (valid4) begin
        nvalid4++;
        if (q4.size() == 0) check("unexpected_valid4", 32'd1, 32'd0);
        else check("rx_data4", {24'd0, data4}, {24'd0, q4.pop_front()});
      end
      if (ferr4) nferr4++;
    end
  end

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx4 = v; else rx16 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input bit sel, input logic [7:0] b, input int cpb);
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input int cpb);
    if (sel) q4.push_back(b); else q16.push_back(b);
    send_data(sel, b, cpb);
    drive(sel, 1'b1, cpb);
  endtask

  initial begin
    int n0, v0, f0, bc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  {24'd0, data16}, 32'd0);
    check("rst_valid", {31'd0, valid16}, 32'd0);
    check("rst_ferr",  {31'd0, ferr16}, 32'd0);
    check("rst_busy",  {31'd0, busy16}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Good frame with latency check
    n0 = cyc;
    valid_cyc = -1;
    send_frame(1'b0, 8'hA5, 16);
    repeat (4) @(posedge clk);
    #1;
    check("latency", valid_cyc - n0, 32'd155);
    check("good_count", nvalid16, 32'd1);
    check("good_data", {24'd0, data16}, 32'hA5);
    check("good_noferr", nferr16, 32'd0);

    // Back-to-back, no idle gap
    send_frame(1'b0, 8'h00, 16);
    send_frame(1'b0, 8'hFF, 16);
    send_frame(1'b0, 8'h3C, 16);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_count", nvalid16, 32'd4);
    check("b2b_last", {24'd0, data16}, 32'h3C);

    // Glitch
    v0 = nvalid16; f0 = nferr16; bc = 0;
    rx16 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx16 = 1'b1;
      @(negedge clk);
      if (busy16) bc++;
      @(posedge clk);
      #1;
    end
    check("glitch_valid", nvalid16, v0);
    check("glitch_ferr", nferr16, f0);
    check("glitch_busy_seen", {31'd0, bc > 0}, 32'd1);
    check("glitch_busy_short", {31'd0, bc < 10}, 32'd1);

    // Framing error: stop held low for 3 bit times
    v0 = nvalid16;
    send_data(1'b0, 8'h55, 16);
    drive(1'b0, 1'b0, 48);
    check("ferr_busy_low", {31'd0, busy16}, 32'd1);
    check("ferr_count", nferr16, 32'd1);
    check("ferr_data_kept", {24'd0, data16}, 32'h3C);
    drive(1'b0, 1'b1, 6);
    check("ferr_busy_release", {31'd0, busy16}, 32'd0);
    check("ferr_novalid", nvalid16, v0);
    send_frame(1'b0, 8'h12, 16);
    repeat (4) @(posedge clk);
    #1;
    check("after_ferr_data", {24'd0, data16}, 32'h12);
    check("after_ferr_count", nvalid16, v0 + 1);

    // Reset during data bit 3 of 0xC3
    v0 = nvalid16;
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b0, 8);
    rst = 1'b1;
    #1;
    check("mid_rst_data", {24'd0, data16}, 32'd0);
    check("mid_rst_busy", {31'd0, busy16}, 32'd0);
    check("mid_rst_valid", {31'd0, valid16}, 32'd0);
    check("mid_rst_ferr", {31'd0, ferr16}, 32'd0);
    rx16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_frame(1'b0, 8'h7E, 16);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_data", {24'd0, data16}, 32'h7E);
    check("post_rst_count", nvalid16, v0 + 1);

    // Minimum divisor
    send_frame(1'b1, 8'h81, 4);
    repeat (4) @(posedge clk);
    #1;
    check("cpb4_data", {24'd0, data4}, 32'h81);
    check("cpb4_count", nvalid4, 32'd1);
    check("cpb4_noferr", nferr4, 32'd0);

    check("q16_drained", q16.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    check("total_ferr16", nferr16, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
